// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam int INST_BYTES = 4;
    localparam int INST_W     = 32;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus between the fetch sequencer and imem.
interface fetch_ctrl_if #(
    parameter int PC_W = 64
);
    import fetch_pkg::*;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_slot.sv
// Single-entry IF/ID output register; flush beats load, load beats consume.
module fetch_slot
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              consume_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o
);
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one imem request at a time,
// and applies trap/branch redirects including those racing an outstanding request.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              trap_valid,
    input  logic [PC_W-1:0]   trap_pc,
    fetch_ctrl_if.master      imem,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              fetch_busy
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;

    logic            slot_free, req, ack_hit, redir, slot_load;
    logic [PC_W-1:0] raw_target, target, pc_inc;

    assign slot_free  = !if_valid || !if_stall;
    assign req        = (state_q == FETCH && slot_free) || (state_q == DROP);
    assign ack_hit    = req && imem.imem_ack;
    assign redir      = trap_valid || redirect_valid;
    assign raw_target = trap_valid ? trap_pc : redirect_pc;
    assign target     = raw_target & ~PC_W'(3);
    assign pc_inc     = req_addr_q + PC_W'(INST_BYTES);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        slot_load  = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redir) begin
                    pc_d       = target;
                    req_addr_d = target;
                end
            end
            FETCH: begin
                if (redir) begin
                    pc_d = target;
                    // A raised request cannot be withdrawn, so let it finish in DROP.
                    if (req && !ack_hit) state_d = DROP;
                    else                 req_addr_d = target;
                end else if (ack_hit) begin
                    slot_load  = 1'b1;
                    pc_d       = pc_inc;
                    req_addr_d = pc_inc;
                end else if (!req) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = FETCH;
                end else if (slot_free) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (redir) pc_d = target;
                if (ack_hit) begin
                    state_d    = FETCH;
                    req_addr_d = redir ? target : pc_q;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_slot #(.PC_W(PC_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load_i    (slot_load),
        .flush_i   (redir),
        .consume_i (if_valid && !if_stall),
        .pc_i      (req_addr_q),
        .inst_i    (imem.imem_rdata),
        .valid_o   (if_valid),
        .pc_o      (if_pc),
        .inst_o    (if_inst)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = req_addr_q;
    assign fetch_busy     = (state_q != FETCH) || !ack_hit;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a latency-programmable imem model and an
// accepted-instruction scoreboard.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int PC_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              trap_valid = 1'b0;
    logic [PC_W-1:0]   trap_pc = '0;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              fetch_busy;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] sb_e;
    logic            prev_pend = 1'b0;
    logic [PC_W-1:0] prev_addr = '0;

    fetch_ctrl_if #(.PC_W(PC_W)) mem ();

    fetch_ctrl #(.PC_W(PC_W), .RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .imem           (mem),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    // imem model: ack after ack_delay waiting cycles, data derived from the address
    assign mem.imem_ack   = mem.imem_req && (wait_cnt >= ack_delay);
    assign mem.imem_rdata = mem.imem_addr[31:0] ^ 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst || !mem.imem_req || mem.imem_ack) wait_cnt <= 0;
        else                                      wait_cnt <= wait_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: an instruction is accepted when decode takes it and no redirect squashes it
    always @(negedge clk) begin
        if (!rst && if_valid && !if_stall && !trap_valid && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected", if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                sb_e = exp_q.pop_front();
                check_val("sb_pc", if_pc, sb_e);
                check_val("sb_inst", {32'h0, if_inst}, {32'h0, sb_e[31:0] ^ 32'hDEAD_BEEF});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_pend <= 1'b0;
        end else begin
            if (prev_pend) begin
                check_val("req_held", {63'h0, mem.imem_req}, 64'h1);
                check_val("addr_held", mem.imem_addr, prev_addr);
            end
            prev_pend <= mem.imem_req && !mem.imem_ack;
            prev_addr <= mem.imem_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [63:0] addr,
                           input logic busy, input logic vld);
        #1;
        check_val({tag, "_req"},  {63'h0, mem.imem_req}, {63'h0, req});
        check_val({tag, "_addr"}, mem.imem_addr, addr);
        check_val({tag, "_busy"}, {63'h0, fetch_busy}, {63'h0, busy});
        check_val({tag, "_vld"},  {63'h0, if_valid}, {63'h0, vld});
    endtask

    initial begin
        repeat (2) cyc();
        chk_out("rst", 1'b0, 64'h1000, 1'b1, 1'b0);
        check_val("rst_pc", if_pc, 64'h0);
        check_val("rst_inst", {32'h0, if_inst}, 64'h0);

        cyc(); rst = 1'b0;                                // cycle 0: BOOT
        chk_out("boot", 1'b0, 64'h1000, 1'b1, 1'b0);
        cyc(); exp_q.push_back(64'h1000);                 // cycle 1: first fetch
        chk_out("c1", 1'b1, 64'h1000, 1'b0, 1'b0);
        cyc(); exp_q.push_back(64'h1004);                 // cycle 2
        chk_out("c2", 1'b1, 64'h1004, 1'b0, 1'b1);
        check_val("c2_pc", if_pc, 64'h1000);

        cyc(); if_stall = 1'b1;                           // cycles 3-6: stalled, slot full
        chk_out("stall0", 1'b0, 64'h1008, 1'b1, 1'b1);
        check_val("stall0_pc", if_pc, 64'h1004);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("stall", 1'b0, 64'h1008, 1'b1, 1'b1);
            check_val("stall_pc", if_pc, 64'h1004);
        end
        cyc(); if_stall = 1'b0; ack_delay = 3;            // cycle 7: stall drops
        chk_out("unstall", 1'b0, 64'h1008, 1'b1, 1'b1);

        cyc(); exp_q.push_back(64'h1008);                 // cycles 8-10: waiting on ack
        chk_out("wait0", 1'b1, 64'h1008, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_out("wait", 1'b1, 64'h1008, 1'b1, 1'b0);
        end
        cyc();                                            // cycle 11: ack
        chk_out("dack", 1'b1, 64'h1008, 1'b0, 1'b0);
        cyc();                                            // cycle 12
        chk_out("dres", 1'b1, 64'h100C, 1'b1, 1'b1);
        check_val("dres_pc", if_pc, 64'h1008);

        cyc(); redirect_valid = 1'b1; redirect_pc = 64'h2003;   // cycle 13: redirect, 0x100C pending
        chk_out("redir", 1'b1, 64'h100C, 1'b1, 1'b0);
        cyc(); redirect_valid = 1'b0;                     // cycle 14: DROP
        chk_out("drop", 1'b1, 64'h100C, 1'b1, 1'b0);
        cyc();                                            // cycle 15: old ack, discarded
        chk_out("dropack", 1'b1, 64'h100C, 1'b1, 1'b0);
        cyc(); ack_delay = 0; exp_q.push_back(64'h2000);  // cycle 16: target fetch
        chk_out("tgt", 1'b1, 64'h2000, 1'b0, 1'b0);
        cyc();                                            // cycle 17
        chk_out("tgt1", 1'b1, 64'h2004, 1'b0, 1'b1);
        check_val("tgt1_pc", if_pc, 64'h2000);

        cyc(); trap_valid = 1'b1; trap_pc = 64'h80;       // cycle 18: trap beats redirect
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        chk_out("trap", 1'b1, 64'h2008, 1'b0, 1'b1);
        cyc(); trap_valid = 1'b0; redirect_valid = 1'b0;  // cycle 19
        exp_q.push_back(64'h80);
        chk_out("trapf", 1'b1, 64'h80, 1'b0, 1'b0);
        cyc();                                            // cycle 20
        chk_out("trap1", 1'b1, 64'h84, 1'b0, 1'b1);
        check_val("trap1_pc", if_pc, 64'h80);

        cyc(); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;  // cycle 21
        chk_out("wrapr", 1'b1, 64'h88, 1'b0, 1'b1);
        cyc(); redirect_valid = 1'b0; exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); // cycle 22
        chk_out("wrapf", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        cyc(); exp_q.push_back(64'h0);                    // cycle 23: wrapped
        chk_out("wrap0", 1'b1, 64'h0, 1'b0, 1'b1);
        check_val("wrap0_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();                                            // cycle 24
        chk_out("wrap1", 1'b1, 64'h4, 1'b0, 1'b1);
        check_val("wrap1_pc", if_pc, 64'h0);

        cyc(); if_stall = 1'b1; ack_delay = 4;            // cycle 25
        chk_out("hold0", 1'b0, 64'h8, 1'b1, 1'b1);
        cyc(); if_stall = 1'b0; exp_q.push_back(64'h4);   // cycle 26: HOLD, slot drains
        chk_out("hold1", 1'b0, 64'h8, 1'b1, 1'b1);
        cyc();                                            // cycle 27: request outstanding
        chk_out("pend", 1'b1, 64'h8, 1'b1, 1'b0);
        rst = 1'b1;                                       // async reset mid-request
        chk_out("mrst", 1'b0, 64'h1000, 1'b1, 1'b0);
        check_val("mrst_pc", if_pc, 64'h0);
        check_val("sb_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
